ahb_lite_sram_slave: RTL and testbench

AHB-Lite slave that consumes the master-side bus signals and acts as the memory-mapped target on the ahb_lite interface. It holds a byte-addressable word RAM and supports programmable wait states, byte/halfword/word transfers and the two-cycle ERROR response. It is the DUT endpoint the monitor observes: the interconnect or testbench feeds its inputs and returns HREADYOUT to the master as HREADY.

---
 rtl/ahb_lite_pkg.sv | 55 +++++
 rtl/ahb_byte_ram.sv | 40 ++++
 rtl/ahb_lite_sram_slave.sv | 159 +++++++++++++++
 tb/tb_ahb_lite_sram_slave.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/ahb_lite_pkg.sv
// ----------------------------------------------------------------------------
// ahb_lite_pkg
// Shared AHB-Lite encodings for the SRAM slave: transfer type, transfer size,
// burst type, response codes, the slave FSM state type and the byte-lane
// strobe helper used by the write path.
// ----------------------------------------------------------------------------
package ahb_lite_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'b000,
        HSIZE_HALF = 3'b001,
        HSIZE_WORD = 3'b010
    } hsize_e;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'b000,
        HBURST_INCR   = 3'b001,
        HBURST_WRAP4  = 3'b010,
        HBURST_INCR4  = 3'b011,
        HBURST_WRAP8  = 3'b100,
        HBURST_INCR8  = 3'b101,
        HBURST_WRAP16 = 3'b110,
        HBURST_INCR16 = 3'b111
    } hburst_e;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_DATA = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } sram_state_e;

    // Little-endian lane strobe. Size is kept as raw bits because an illegal
    // size can be latched on an ERROR transfer; such transfers never write.
    function automatic logic [3:0] byte_strobe(input logic [2:0] hsize,
                                               input logic [1:0] off);
        case (hsize)
            HSIZE_BYTE: byte_strobe = 4'b0001 << off;
            HSIZE_HALF: byte_strobe = 4'b0011 << {off[1], 1'b0};
            default:    byte_strobe = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/ahb_byte_ram.sv
// ----------------------------------------------------------------------------
// ahb_byte_ram
// MEM_WORDS x 32-bit RAM with per-byte write strobes and an asynchronous read
// port sharing the same word address.
//   clk   : write clock
//   we    : write enable
//   addr  : word address (read and write)
//   strb  : byte-lane write strobes, bit i enables wdata[8i+7:8i]
//   wdata : write data
//   rdata : word at addr (combinational)
// ----------------------------------------------------------------------------
module ahb_byte_ram #(
    parameter int unsigned MEM_WORDS = 1024,
    localparam int unsigned AW = $clog2(MEM_WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [3:0]    strb,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [MEM_WORDS];

    // NOTE: the array has no reset; clearing a RAM costs a write port per
    // word and the bus contract never promises initial contents.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (strb[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/ahb_lite_sram_slave.sv
// ----------------------------------------------------------------------------
// ahb_lite_sram_slave
// AHB-Lite SRAM target with programmable wait states, byte/half/word transfers
// and the two-cycle ERROR response.
//   HCLK, HRESET        : clock, synchronous active-high reset
//   HSEL, HADDR, HTRANS,
//   HWRITE, HSIZE       : address-phase controls (sampled when HREADY=1)
//   HBURST, HPROT,
//   HMASTLOCK           : accepted but not used
//   HWDATA              : write data (data phase)
//   HREADY              : bus-level ready, qualifies the address phase
//   HRDATA              : read data, full word during the OKAY data cycle
//   HREADYOUT, HRESP    : slave ready and response
// ----------------------------------------------------------------------------
module ahb_lite_sram_slave
    import ahb_lite_pkg::*;
#(
    parameter int unsigned MEM_WORDS   = 1024,
    parameter int unsigned WAIT_STATES = 0,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [3:0]  HPROT,
    input  logic        HMASTLOCK,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP
);

    localparam int unsigned AW        = $clog2(MEM_WORDS);
    localparam logic [31:0] MEM_BYTES = 32'(4 * MEM_WORDS);
    localparam logic [3:0]  WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    sram_state_e   state;
    logic [3:0]    wait_cnt;
    logic          ready_q;
    logic          resp_q;

    // Address-phase latch for the transfer currently in its data phase.
    logic [AW-1:0] lat_word;
    logic [1:0]    lat_off;
    logic [2:0]    lat_size;
    logic          lat_write;
    logic          lat_err;

    logic [31:0]   offset;
    logic          accept;
    logic          can_accept;
    logic          addr_err;
    logic          ram_we;
    logic [31:0]   ram_rdata;
    logic          unused_ok;

    assign offset     = HADDR - BASE_ADDR;
    assign accept     = HSEL && HREADY && HTRANS[1];
    // Only cycles that drive HREADYOUT=1 can end an address phase.
    assign can_accept = (state == ST_IDLE) || (state == ST_DATA) || (state == ST_ERR2);
    assign addr_err   = (offset >= MEM_BYTES)
                     || (HSIZE > HSIZE_WORD)
                     || ((HSIZE == HSIZE_HALF) && HADDR[0])
                     || ((HSIZE == HSIZE_WORD) && (HADDR[1:0] != 2'b00));

    assign unused_ok  = ^{HTRANS[0], HBURST, HPROT, HMASTLOCK};

    // NOTE: state registers use non-blocking assignments so every branch
    // sees the pre-edge values, independent of statement order.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state     <= ST_IDLE;
            ready_q   <= 1'b1;
            resp_q    <= HRESP_OKAY;
            wait_cnt  <= '0;
            lat_word  <= '0;
            lat_off   <= '0;
            lat_size  <= '0;
            lat_write <= 1'b0;
            lat_err   <= 1'b0;
        end else begin
            if (accept && can_accept) begin
                lat_word  <= offset[AW+1:2];
                lat_off   <= offset[1:0];
                lat_size  <= HSIZE;
                lat_write <= HWRITE;
                lat_err   <= addr_err;
            end

            case (state)
                ST_IDLE, ST_DATA, ST_ERR2: begin
                    if (accept) begin
                        if (addr_err) begin
                            state   <= ST_ERR1;
                            ready_q <= 1'b0;
                            resp_q  <= HRESP_ERROR;
                        end else if (WAIT_STATES > 0) begin
                            state    <= ST_WAIT;
                            wait_cnt <= WAIT_LOAD;
                            ready_q  <= 1'b0;
                            resp_q   <= HRESP_OKAY;
                        end else begin
                            state   <= ST_DATA;
                            ready_q <= 1'b1;
                            resp_q  <= HRESP_OKAY;
                        end
                    end else begin
                        state   <= ST_IDLE;
                        ready_q <= 1'b1;
                        resp_q  <= HRESP_OKAY;
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state   <= ST_DATA;
                        ready_q <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                ST_ERR1: begin
                    state   <= ST_ERR2;
                    ready_q <= 1'b1;
                end
                default: begin
                    state   <= ST_IDLE;
                    ready_q <= 1'b1;
                    resp_q  <= HRESP_OKAY;
                end
            endcase
        end
    end

    // The write lands on the edge that closes DATA, so a read pipelined right
    // behind it sees the new word. A reset on that edge cancels the write.
    assign ram_we = (state == ST_DATA) && lat_write && !lat_err && !HRESET;

    ahb_byte_ram #(
        .MEM_WORDS (MEM_WORDS)
    ) u_ram (
        .clk   (HCLK),
        .we    (ram_we),
        .addr  (lat_word),
        .strb  (byte_strobe(lat_size, lat_off)),
        .wdata (HWDATA),
        .rdata (ram_rdata)
    );

    assign HRDATA    = (state == ST_DATA) ? ram_rdata : 32'h0;
    assign HREADYOUT = ready_q;
    assign HRESP     = resp_q;

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// ----------------------------------------------------------------------------
// tb_ahb_lite_sram_slave
// Two slaves share the bus signals: dut0 (no wait states) and dut3 (three
// wait states). use3 picks which one is selected and which one drives HREADY
// back, as an interconnect would. Each table row is one clock cycle: the
// address-phase and HWDATA values to drive, and the HREADYOUT/HRESP/HRDATA
// the selected slave must show in that cycle.
// ----------------------------------------------------------------------------
module tb_ahb_lite_sram_slave;
    import ahb_lite_pkg::*;

    localparam logic [1:0] ID = 2'b00, BS = 2'b01, NS = 2'b10, SQ = 2'b11;
    localparam logic [2:0] SB = 3'b000, SH = 3'b001, SW = 3'b010, SX = 3'b011;

    typedef struct {
        logic        u3;
        logic        rst;
        logic        sel;
        logic [1:0]  trans;
        logic        wr;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_ready;
        logic        exp_resp;
        logic        chk_data;
        logic [31:0] exp_data;
    } vec_t;

    logic        clk = 1'b0;
    logic        hreset, hsel, use3, hwrite, hmastlock;
    logic [1:0]  htrans;
    logic [2:0]  hsize, hburst;
    logic [3:0]  hprot;
    logic [31:0] haddr, hwdata;
    logic        hsel0, hsel3, hready;
    logic [31:0] rdata0, rdata3, rdata_mux;
    logic        ready0, ready3, resp0, resp3, resp_mux;

    int tests  = 0;
    int failed = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    assign hsel0     = hsel & ~use3;
    assign hsel3     = hsel & use3;
    assign hready    = use3 ? ready3 : ready0;
    assign resp_mux  = use3 ? resp3 : resp0;
    assign rdata_mux = use3 ? rdata3 : rdata0;

    ahb_lite_sram_slave #(.MEM_WORDS(1024), .WAIT_STATES(0), .BASE_ADDR(32'h0)) dut0 (
        .HCLK(clk), .HRESET(hreset), .HSEL(hsel0), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot),
        .HMASTLOCK(hmastlock), .HWDATA(hwdata), .HREADY(hready),
        .HRDATA(rdata0), .HREADYOUT(ready0), .HRESP(resp0)
    );

    ahb_lite_sram_slave #(.MEM_WORDS(1024), .WAIT_STATES(3), .BASE_ADDR(32'h0)) dut3 (
        .HCLK(clk), .HRESET(hreset), .HSEL(hsel3), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot),
        .HMASTLOCK(hmastlock), .HWDATA(hwdata), .HREADY(hready),
        .HRDATA(rdata3), .HREADYOUT(ready3), .HRESP(resp3)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic u3, input logic rst, input logic sel, input logic [1:0] trans,
                       input logic wr, input logic [2:0] size, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic er, input logic ersp,
                       input logic chk, input logic [31:0] ed);
        vec_t v;
        v = '{u3, rst, sel, trans, wr, size, addr, wdata, er, ersp, chk, ed};
        vecs.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          waited;
        logic        done;
        logic [31:0] got;

        hreset = 1'b1; hsel = 1'b0; use3 = 1'b0; htrans = ID; hwrite = 1'b0;
        hsize = SW; haddr = '0; hwdata = '0; hburst = HBURST_INCR4; hprot = 4'h3;
        hmastlock = 1'b0;

        //   u3 rst sel trans wr size addr          wdata          rdy rsp chk data
        // Reset holds off a presented transfer, then the reset state.
        add(0, 1, 1, NS, 0, SW, 32'h10,       32'h0,         1, 0, 1, 32'h0);
        add(0, 0, 1, ID, 0, SW, 32'h0,        32'h0,         1, 0, 1, 32'h0);
        // Word write then read, byte and half overwrites, each read back.
        add(0, 0, 1, NS, 1, SW, 32'h10,       32'h0,         1, 0, 1, 32'h0);
        add(0, 0, 1, NS, 0, SW, 32'h10,       32'hDEAD_BEEF, 1, 0, 0, 32'h0);
        add(0, 0, 1, NS, 1, SB, 32'h13,       32'h0,         1, 0, 1, 32'hDEAD_BEEF);
        add(0, 0, 1, NS, 0, SW, 32'h10,       32'hA500_0000, 1, 0, 0, 32'h0);
        add(0, 0, 1, NS, 1, SH, 32'h12,       32'h0,         1, 0, 1, 32'hA5AD_BEEF);
        add(0, 0, 1, NS, 0, SW, 32'h10,       32'h1234_0000, 1, 0, 0, 32'h0);
        add(0, 0, 1, ID, 0, SW, 32'h0,        32'h0,         1, 0, 1, 32'h1234_BEEF);
        add(0, 0, 1, ID, 0, SW, 32'h0,        32'h0,         1, 0, 1, 32'h0);
        // Misaligned read, then out-of-range write (would alias word 4 if
        // the range check were missing), then a read held through ERR1.
        add(0, 0, 1, NS, 0, SW, 32'h11,       32'h0,         1, 0, 1, 32'h0);
        add(0, 0, 1, ID, 0, SW, 32'h0,        32'h0,         0, 1, 1, 32'h0);
        add(0, 0, 1, NS, 1, SW, 32'h1010,     32'h0,         1, 1, 1, 32'h0);
        add(0, 0, 1, NS, 0, SW, 32'h10,       32'hFFFF_FFFF, 0, 1, 1, 32'h0);
        add(0, 0, 1, NS, 0, SW, 32'h10,       32'hFFFF_FFFF, 1, 1, 1, 32'h0);
        add(0, 0, 1, ID, 0, SW, 32'h0,        32'h0,         1, 0, 1, 32'h1234_BEEF);
        // Unselected write is ignored; the word still reads back unchanged.
        add(0, 0, 0, NS, 1, SW, 32'h10,       32'h0,         1, 0, 1, 32'h0);
        add(0, 0, 1, NS, 0, SW, 32'h10,       32'h5555_5555, 1, 0, 1, 32'h0);
        // INCR4 writes 0x20..0x2C with a BUSY beat inside.
        add(0, 0, 1, NS, 1, SW, 32'h20,       32'h0,         1, 0, 1, 32'h1234_BEEF);
        add(0, 0, 1, SQ, 1, SW, 32'h24,       32'h1111_1111, 1, 0, 0, 32'h0);
        add(0, 0, 1, BS, 1, SW, 32'h28,       32'h2222_2222, 1, 0, 0, 32'h0);
        add(0, 0, 1, SQ, 1, SW, 32'h28,       32'h0,         1, 0, 1, 32'h0);
        add(0, 0, 1, SQ, 1, SW, 32'h2C,       32'h3333_3333, 1, 0, 0, 32'h0);
        // WRAP4 read from 0x28 with a BUSY beat inside.
        add(0, 0, 1, NS, 0, SW, 32'h28,       32'h4444_4444, 1, 0, 0, 32'h0);
        add(0, 0, 1, SQ, 0, SW, 32'h2C,       32'h0,         1, 0, 1, 32'h3333_3333);
        add(0, 0, 1, BS, 0, SW, 32'h20,       32'h0,         1, 0, 1, 32'h4444_4444);
        add(0, 0, 1, SQ, 0, SW, 32'h20,       32'h0,         1, 0, 1, 32'h0);
        add(0, 0, 1, SQ, 0, SW, 32'h24,       32'h0,         1, 0, 1, 32'h1111_1111);
        add(0, 0, 1, ID, 0, SW, 32'h0,        32'h0,         1, 0, 1, 32'h2222_2222);
        // Illegal HSIZE.
        add(0, 0, 1, NS, 0, SX, 32'h20,       32'h0,         1, 0, 1, 32'h0);
        add(0, 0, 1, ID, 0, SW, 32'h0,        32'h0,         0, 1, 1, 32'h0);
        add(0, 0, 1, ID, 0, SW, 32'h0,        32'h0,         1, 1, 1, 32'h0);
        add(0, 0, 1, ID, 0, SW, 32'h0,        32'h0,         1, 0, 1, 32'h0);
        // Three wait states: write, read held by the stall, SEQ read held.
        add(1, 0, 1, NS, 1, SW, 32'h40,       32'h0,         1, 0, 1, 32'h0);
        add(1, 0, 1, NS, 0, SW, 32'h40,       32'hCAFE_F00D, 0, 0, 1, 32'h0);
        add(1, 0, 1, NS, 0, SW, 32'h40,       32'hCAFE_F00D, 0, 0, 1, 32'h0);
        add(1, 0, 1, NS, 0, SW, 32'h40,       32'hCAFE_F00D, 0, 0, 1, 32'h0);
        add(1, 0, 1, NS, 0, SW, 32'h40,       32'hCAFE_F00D, 1, 0, 0, 32'h0);
        add(1, 0, 1, SQ, 0, SW, 32'h40,       32'h0,         0, 0, 1, 32'h0);
        add(1, 0, 1, SQ, 0, SW, 32'h40,       32'h0,         0, 0, 1, 32'h0);
        add(1, 0, 1, SQ, 0, SW, 32'h40,       32'h0,         0, 0, 1, 32'h0);
        add(1, 0, 1, SQ, 0, SW, 32'h40,       32'h0,         1, 0, 1, 32'hCAFE_F00D);
        add(1, 0, 1, ID, 0, SW, 32'h0,        32'h0,         0, 0, 1, 32'h0);
        add(1, 0, 1, ID, 0, SW, 32'h0,        32'h0,         0, 0, 1, 32'h0);
        add(1, 0, 1, ID, 0, SW, 32'h0,        32'h0,         0, 0, 1, 32'h0);
        add(1, 0, 1, ID, 0, SW, 32'h0,        32'h0,         1, 0, 1, 32'hCAFE_F00D);
        add(1, 0, 1, ID, 0, SW, 32'h0,        32'h0,         1, 0, 1, 32'h0);
        // Reset during the first wait cycle of a write aborts it.
        add(1, 0, 1, NS, 1, SW, 32'h40,       32'h0,         1, 0, 1, 32'h0);
        add(1, 1, 1, ID, 0, SW, 32'h0,        32'h0BAD_0BAD, 0, 0, 1, 32'h0);
        add(1, 0, 1, NS, 0, SW, 32'h40,       32'h0BAD_0BAD, 1, 0, 1, 32'h0);
        add(1, 0, 1, ID, 0, SW, 32'h0,        32'h0BAD_0BAD, 0, 0, 1, 32'h0);
        add(1, 0, 1, ID, 0, SW, 32'h0,        32'h0BAD_0BAD, 0, 0, 1, 32'h0);
        add(1, 0, 1, ID, 0, SW, 32'h0,        32'h0BAD_0BAD, 0, 0, 1, 32'h0);
        add(1, 0, 1, ID, 0, SW, 32'h0,        32'h0,         1, 0, 1, 32'hCAFE_F00D);
        add(1, 0, 1, ID, 0, SW, 32'h0,        32'h0,         1, 0, 1, 32'h0);

        repeat (2) @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            use3   = vecs[i].u3;
            hreset = vecs[i].rst;
            hsel   = vecs[i].sel;
            htrans = vecs[i].trans;
            hwrite = vecs[i].wr;
            hsize  = vecs[i].size;
            haddr  = vecs[i].addr;
            hwdata = vecs[i].wdata;
            @(negedge clk);
            check($sformatf("v%0d hreadyout", i), {31'b0, hready}, {31'b0, vecs[i].exp_ready});
            check($sformatf("v%0d hresp", i), {31'b0, resp_mux}, {31'b0, vecs[i].exp_resp});
            if (vecs[i].chk_data) begin
                check($sformatf("v%0d hrdata", i), rdata_mux, vecs[i].exp_data);
            end
            @(posedge clk);
            #1;
        end

        // Count the stall of one read on dut3, bounded so a stuck slave
        // still reaches the summary.
        use3 = 1'b1; hreset = 1'b0; hsel = 1'b1; htrans = NS; hwrite = 1'b0;
        hsize = SW; haddr = 32'h40; hwdata = '0;
        @(posedge clk);
        #1;
        htrans = ID;
        waited = 0;
        done   = 1'b0;
        got    = '0;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            if (hready) begin
                done = 1'b1;
                got  = rdata_mux;
                check("stall hresp", {31'b0, resp_mux}, {31'b0, HRESP_OKAY});
            end else begin
                waited++;
            end
            @(posedge clk);
            #1;
        end
        check("stall completed", {31'b0, done}, 32'd1);
        check("stall cycles", 32'(waited), 32'd3);
        check("stall hrdata", got, 32'hCAFE_F00D);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
